// File: rtl/regbank_pkg.sv
// Shared definitions for the register bank: clear-FSM state encoding and
// parameter defaults used by register_bank, its interface and its clear sequencer.
package regbank_pkg;

    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned ADDR_W_DEF   = 5;
    localparam int unsigned DEPTH_DEF    = 32;
    localparam bit          ZERO_REG_DEF = 1'b1;
    localparam bit          BYPASS_DEF   = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/register_bank_if.sv
// Register bank bus: two read ports, one byte-enabled write port and the
// clear handshake (clr in, busy/clr_done out).
//   master : drives addresses, write data/enables, reg_w, clr
//   slave  : drives r_data1/r_data2, busy, clr_done
interface register_bank_if
    import regbank_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
);

    logic [ADDR_W-1:0]   r_reg1;
    logic [ADDR_W-1:0]   r_reg2;
    logic [DATA_W-1:0]   r_data1;
    logic [DATA_W-1:0]   r_data2;
    logic [ADDR_W-1:0]   w_reg_addr;
    logic [DATA_W-1:0]   w_data;
    logic [DATA_W/8-1:0] w_be;
    logic                reg_w;
    logic                clr;
    logic                busy;
    logic                clr_done;

    modport master (
        output r_reg1, r_reg2, w_reg_addr, w_data, w_be, reg_w, clr,
        input  r_data1, r_data2, busy, clr_done
    );

    modport slave (
        input  r_reg1, r_reg2, w_reg_addr, w_data, w_be, reg_w, clr,
        output r_data1, r_data2, busy, clr_done
    );

endinterface

// File: rtl/regbank_clr_seq.sv
// Sequential clear engine: on clr walks an index 0..DEPTH-1, one entry per
// cycle, and pulses clr_done on the last one. clr is ignored while clearing.
//   clk, rst_n : clock, async active-low reset (aborts a clear in progress)
//   clr        : start pulse
//   busy       : high for exactly DEPTH cycles per clear
//   clr_done   : one-cycle pulse on the final clear cycle
//   clr_idx    : entry to zero this cycle
//   clr_en     : zero mem[clr_idx] at the next edge
module regbank_clr_seq
    import regbank_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] clr_idx,
    output logic              clr_en
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              done_q, done_d;

    // State, counter and done pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next state; done is pre-decoded so it is registered alongside the final index
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        done_d = (state_d == CLEAR) && (cnt_d == LAST_IDX);
    end

    assign busy     = (state_q == CLEAR);
    assign clr_en   = (state_q == CLEAR);
    assign clr_idx  = cnt_q;
    assign clr_done = done_q;

endmodule

// File: rtl/register_bank.sv
// Two-read / one-write register file with byte enables, optional hardwired
// zero entry, optional write-to-read forwarding and a sequential clear.
//   clk, rst_n : clock, async active-low reset (zeroes every entry)
//   bus        : register_bank_if slave (reads, byte-enabled write, clear handshake)
module register_bank
    import regbank_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter bit          ZERO_REG = ZERO_REG_DEF,
    parameter bit          BYPASS   = BYPASS_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    register_bank_if.slave  bus
);

    localparam int unsigned NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              busy;
    logic              clr_en;
    logic [ADDR_W-1:0] clr_idx;
    logic              w_ok_c;
    logic [DATA_W-1:0] w_merged_c;
    logic [DATA_W-1:0] rd1_c;
    logic [DATA_W-1:0] rd2_c;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    function automatic logic zero_hit(input logic [ADDR_W-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    regbank_clr_seq #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clr_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (bus.clr),
        .busy     (busy),
        .clr_done (bus.clr_done),
        .clr_idx  (clr_idx),
        .clr_en   (clr_en)
    );

    // Write qualification and byte merge over the current entry
    always_comb begin
        w_ok_c     = bus.reg_w && !busy && addr_ok(bus.w_reg_addr) && !zero_hit(bus.w_reg_addr);
        w_merged_c = addr_ok(bus.w_reg_addr) ? mem[bus.w_reg_addr] : '0;
        for (int k = 0; k < NB; k++) begin
            if (bus.w_be[k]) begin
                w_merged_c[k*8 +: 8] = bus.w_data[k*8 +: 8];
            end
        end
    end

    // Read port 1; forwarding only fires for a qualifying write
    always_comb begin
        rd1_c = '0;
        if (addr_ok(bus.r_reg1) && !zero_hit(bus.r_reg1)) begin
            if (BYPASS && w_ok_c && (bus.r_reg1 == bus.w_reg_addr)) begin
                rd1_c = w_merged_c;
            end else begin
                rd1_c = mem[bus.r_reg1];
            end
        end
    end

    // Read port 2
    always_comb begin
        rd2_c = '0;
        if (addr_ok(bus.r_reg2) && !zero_hit(bus.r_reg2)) begin
            if (BYPASS && w_ok_c && (bus.r_reg2 == bus.w_reg_addr)) begin
                rd2_c = w_merged_c;
            end else begin
                rd2_c = mem[bus.r_reg2];
            end
        end
    end

    assign bus.r_data1 = rd1_c;
    assign bus.r_data2 = rd2_c;
    assign bus.busy    = busy;

    // Storage; writes are blocked while clearing so the two never collide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_en) begin
            mem[clr_idx] <= '0;
        end else if (w_ok_c) begin
            mem[bus.w_reg_addr] <= w_merged_c;
        end
    end

endmodule

// File: tb/tb_register_bank.sv
// Directed bench: instance A uses defaults (DEPTH=32, BYPASS=1), instance B
// uses DEPTH=20, BYPASS=0; both receive identical stimulus.
module tb_register_bank;
    import regbank_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  r_reg1, r_reg2, w_reg_addr;
    logic [31:0] w_data;
    logic [3:0]  w_be;
    logic        reg_w, clr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    register_bank_if #(.DATA_W(32), .ADDR_W(5)) bus_a();
    register_bank_if #(.DATA_W(32), .ADDR_W(5)) bus_b();

    assign bus_a.r_reg1 = r_reg1;         assign bus_b.r_reg1 = r_reg1;
    assign bus_a.r_reg2 = r_reg2;         assign bus_b.r_reg2 = r_reg2;
    assign bus_a.w_reg_addr = w_reg_addr; assign bus_b.w_reg_addr = w_reg_addr;
    assign bus_a.w_data = w_data;         assign bus_b.w_data = w_data;
    assign bus_a.w_be = w_be;             assign bus_b.w_be = w_be;
    assign bus_a.reg_w = reg_w;           assign bus_b.reg_w = reg_w;
    assign bus_a.clr = clr;               assign bus_b.clr = clr;

    register_bank #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut_a (
        .clk (clk), .rst_n (rst_n), .bus (bus_a)
    );

    register_bank #(.DATA_W(32), .ADDR_W(5), .DEPTH(20), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_b (
        .clk (clk), .rst_n (rst_n), .bus (bus_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; r_reg1 = 5'd5; r_reg2 = 5'd31; w_reg_addr = '0;
        w_data = '0; w_be = '0; reg_w = 1'b0; clr = 1'b0;
        #2;
        n_cmp++; if (bus_a.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy_a: got %b expected 0", bus_a.busy); end
        n_cmp++; if (bus_a.clr_done !== 1'b0) begin n_bad++; $display("FAIL reset_done_a: got %b expected 0", bus_a.clr_done); end
        n_cmp++; if (bus_a.r_data1 !== 32'h0) begin n_bad++; $display("FAIL reset_rd_a: got %h expected 0", bus_a.r_data1); end
        n_cmp++; if (bus_b.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy_b: got %b expected 0", bus_b.busy); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_full_write();
        w_reg_addr = 5'd5; w_data = 32'hDEADBEEF; w_be = 4'hF; reg_w = 1'b1;
        tick();
        reg_w = 1'b0; r_reg1 = 5'd5;
        #1;
        n_cmp++; if (bus_a.r_data1 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL full_write_a: got %h expected deadbeef", bus_a.r_data1); end
        n_cmp++; if (bus_b.r_data1 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL full_write_b: got %h expected deadbeef", bus_b.r_data1); end
    endtask

    task automatic test_byte_enable();
        w_reg_addr = 5'd5; w_data = 32'h11223344; w_be = 4'b0101; reg_w = 1'b1;
        tick();
        reg_w = 1'b0;
        #1;
        n_cmp++; if (bus_a.r_data1 !== 32'hDE22BE44) begin n_bad++; $display("FAIL byte_en_a: got %h expected de22be44", bus_a.r_data1); end
        w_data = 32'hFFFFFFFF; w_be = 4'b0000; reg_w = 1'b1;
        tick();
        reg_w = 1'b0;
        #1;
        n_cmp++; if (bus_a.r_data1 !== 32'hDE22BE44) begin n_bad++; $display("FAIL be_zero_a: got %h expected de22be44", bus_a.r_data1); end
        n_cmp++; if (bus_b.r_data1 !== 32'hDE22BE44) begin n_bad++; $display("FAIL be_zero_b: got %h expected de22be44", bus_b.r_data1); end
    endtask

    task automatic test_bypass();
        r_reg1 = 5'd7; r_reg2 = 5'd7;
        w_reg_addr = 5'd7; w_data = 32'hA5A5A5A5; w_be = 4'hF; reg_w = 1'b1;
        #1;
        n_cmp++; if (bus_a.r_data2 !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL bypass_a: got %h expected a5a5a5a5", bus_a.r_data2); end
        n_cmp++; if (bus_a.r_data1 !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL bypass_same_addr_a: got %h expected a5a5a5a5", bus_a.r_data1); end
        n_cmp++; if (bus_b.r_data2 !== 32'h0) begin n_bad++; $display("FAIL no_bypass_b: got %h expected 0", bus_b.r_data2); end
        tick();
        reg_w = 1'b0;
        #1;
        n_cmp++; if (bus_b.r_data2 !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL no_bypass_next_b: got %h expected a5a5a5a5", bus_b.r_data2); end
        // partial-byte forward over an existing entry
        r_reg1 = 5'd5; w_reg_addr = 5'd5; w_data = 32'h0; w_be = 4'b0011; reg_w = 1'b1;
        #1;
        n_cmp++; if (bus_a.r_data1 !== 32'hDE220000) begin n_bad++; $display("FAIL bypass_merge_a: got %h expected de220000", bus_a.r_data1); end
        n_cmp++; if (bus_b.r_data1 !== 32'hDE22BE44) begin n_bad++; $display("FAIL no_bypass_merge_b: got %h expected de22be44", bus_b.r_data1); end
        tick();
        reg_w = 1'b0;
        #1;
        n_cmp++; if (bus_b.r_data1 !== 32'hDE220000) begin n_bad++; $display("FAIL merge_commit_b: got %h expected de220000", bus_b.r_data1); end
    endtask

    task automatic test_zero_and_range();
        r_reg1 = 5'd0; w_reg_addr = 5'd0; w_data = 32'hFFFFFFFF; w_be = 4'hF; reg_w = 1'b1;
        #1;
        n_cmp++; if (bus_a.r_data1 !== 32'h0) begin n_bad++; $display("FAIL zero_reg_fwd_a: got %h expected 0", bus_a.r_data1); end
        tick();
        reg_w = 1'b0;
        #1;
        n_cmp++; if (bus_a.r_data1 !== 32'h0) begin n_bad++; $display("FAIL zero_reg_a: got %h expected 0", bus_a.r_data1); end
        n_cmp++; if (bus_b.r_data1 !== 32'h0) begin n_bad++; $display("FAIL zero_reg_b: got %h expected 0", bus_b.r_data1); end
        r_reg2 = 5'd25; w_reg_addr = 5'd25; w_data = 32'h12345678; reg_w = 1'b1;
        tick();
        reg_w = 1'b0;
        #1;
        n_cmp++; if (bus_a.r_data2 !== 32'h12345678) begin n_bad++; $display("FAIL addr25_a: got %h expected 12345678", bus_a.r_data2); end
        n_cmp++; if (bus_b.r_data2 !== 32'h0) begin n_bad++; $display("FAIL out_of_range_b: got %h expected 0", bus_b.r_data2); end
    endtask

    task automatic test_clear();
        logic [31:0] exp3, exp31;
        w_be = 4'hF;
        for (int i = 1; i < 32; i++) begin
            w_reg_addr = 5'(i); w_data = 32'h1000_0000 + 32'(i); reg_w = 1'b1;
            tick();
        end
        reg_w = 1'b0;
        r_reg1 = 5'd3; r_reg2 = 5'd31;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            reg_w = (c == 2); w_reg_addr = 5'd31; w_data = 32'h0;
            clr = (c == 10);
            #1;
            exp3  = (c >= 5) ? 32'h0 : 32'h1000_0003;
            exp31 = 32'h1000_001F;
            n_cmp++; if (bus_a.busy !== 1'b1) begin n_bad++; $display("FAIL clr_busy_a c=%0d: got %b expected 1", c, bus_a.busy); end
            n_cmp++; if (bus_a.clr_done !== (c == 32)) begin n_bad++; $display("FAIL clr_done_a c=%0d: got %b expected %b", c, bus_a.clr_done, c == 32); end
            n_cmp++; if (bus_a.r_data1 !== exp3) begin n_bad++; $display("FAIL clr_entry3_a c=%0d: got %h expected %h", c, bus_a.r_data1, exp3); end
            n_cmp++; if (bus_a.r_data2 !== exp31) begin n_bad++; $display("FAIL clr_entry31_a c=%0d: got %h expected %h", c, bus_a.r_data2, exp31); end
            n_cmp++; if (bus_b.busy !== (c <= 20)) begin n_bad++; $display("FAIL clr_busy_b c=%0d: got %b expected %b", c, bus_b.busy, c <= 20); end
            n_cmp++; if (bus_b.clr_done !== (c == 20)) begin n_bad++; $display("FAIL clr_done_b c=%0d: got %b expected %b", c, bus_b.clr_done, c == 20); end
            tick();
        end
        reg_w = 1'b0; clr = 1'b0;
        #1;
        n_cmp++; if (bus_a.busy !== 1'b0) begin n_bad++; $display("FAIL clr_end_busy_a: got %b expected 0", bus_a.busy); end
        n_cmp++; if (bus_a.clr_done !== 1'b0) begin n_bad++; $display("FAIL clr_end_done_a: got %b expected 0", bus_a.clr_done); end
        n_cmp++; if (bus_a.r_data2 !== 32'h0) begin n_bad++; $display("FAIL clr_end_entry31_a: got %h expected 0", bus_a.r_data2); end
        n_cmp++; if (bus_b.r_data1 !== 32'h0) begin n_bad++; $display("FAIL clr_end_entry3_b: got %h expected 0", bus_b.r_data1); end
    endtask

    task automatic test_clr_with_write();
        bit ended;
        r_reg1 = 5'd9; w_reg_addr = 5'd9; w_data = 32'h0000_0055; w_be = 4'hF;
        reg_w = 1'b1; clr = 1'b1;
        #1;
        n_cmp++; if (bus_a.r_data1 !== 32'h55) begin n_bad++; $display("FAIL clr_wr_fwd_a: got %h expected 55", bus_a.r_data1); end
        tick();
        reg_w = 1'b0; clr = 1'b0;
        #1;
        n_cmp++; if (bus_a.busy !== 1'b1) begin n_bad++; $display("FAIL clr_wr_busy_a: got %b expected 1", bus_a.busy); end
        n_cmp++; if (bus_a.r_data1 !== 32'h55) begin n_bad++; $display("FAIL clr_wr_commit_a: got %h expected 55", bus_a.r_data1); end
        n_cmp++; if (bus_b.r_data1 !== 32'h55) begin n_bad++; $display("FAIL clr_wr_commit_b: got %h expected 55", bus_b.r_data1); end
        ended = 1'b0;
        for (int k = 0; k < 40 && !ended; k++) begin
            tick();
            if (!bus_a.busy) ended = 1'b1;
        end
        n_cmp++; if (ended !== 1'b1) begin n_bad++; $display("FAIL clr_wr_timeout: busy still %b expected 0", bus_a.busy); end
        #1;
        n_cmp++; if (bus_a.r_data1 !== 32'h0) begin n_bad++; $display("FAIL clr_wr_erased_a: got %h expected 0", bus_a.r_data1); end
        n_cmp++; if (bus_b.r_data1 !== 32'h0) begin n_bad++; $display("FAIL clr_wr_erased_b: got %h expected 0", bus_b.r_data1); end
    endtask

    task automatic test_async_reset();
        logic seen_done, seen_busy;
        w_be = 4'hF;
        w_reg_addr = 5'd20; w_data = 32'hCAFEF00D; reg_w = 1'b1;
        tick();
        w_reg_addr = 5'd31; w_data = 32'h0BADF00D;
        tick();
        reg_w = 1'b0; r_reg1 = 5'd20; r_reg2 = 5'd31;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (9) tick();
        #3;
        n_cmp++; if (bus_a.busy !== 1'b1) begin n_bad++; $display("FAIL pre_rst_busy_a: got %b expected 1", bus_a.busy); end
        n_cmp++; if (bus_a.r_data2 !== 32'h0BADF00D) begin n_bad++; $display("FAIL pre_rst_entry31_a: got %h expected 0badf00d", bus_a.r_data2); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus_a.busy !== 1'b0) begin n_bad++; $display("FAIL async_rst_busy_a: got %b expected 0", bus_a.busy); end
        n_cmp++; if (bus_a.clr_done !== 1'b0) begin n_bad++; $display("FAIL async_rst_done_a: got %b expected 0", bus_a.clr_done); end
        n_cmp++; if (bus_a.r_data1 !== 32'h0) begin n_bad++; $display("FAIL async_rst_entry20_a: got %h expected 0", bus_a.r_data1); end
        n_cmp++; if (bus_a.r_data2 !== 32'h0) begin n_bad++; $display("FAIL async_rst_entry31_a: got %h expected 0", bus_a.r_data2); end
        n_cmp++; if (bus_b.busy !== 1'b0) begin n_bad++; $display("FAIL async_rst_busy_b: got %b expected 0", bus_b.busy); end
        #2;
        rst_n = 1'b1;
        seen_done = 1'b0; seen_busy = 1'b0;
        repeat (40) begin
            tick();
            seen_done |= bus_a.clr_done | bus_b.clr_done;
            seen_busy |= bus_a.busy | bus_b.busy;
        end
        n_cmp++; if (seen_done !== 1'b0) begin n_bad++; $display("FAIL post_rst_done: got %b expected 0", seen_done); end
        n_cmp++; if (seen_busy !== 1'b0) begin n_bad++; $display("FAIL post_rst_busy: got %b expected 0", seen_busy); end
    endtask

    initial begin
        test_reset();
        test_full_write();
        test_byte_enable();
        test_bypass();
        test_zero_and_range();
        test_clear();
        test_clr_with_write();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
